// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] FETCH_ERR_NONE     = 2'b00;
    localparam logic [1:0] FETCH_ERR_MISALIGN = 2'b01;
    localparam logic [1:0] FETCH_ERR_RANGE    = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline holding register: flush beats load, load beats drain, otherwise hold.
module ifid_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= 32'h0;
            pc       <= 32'h0;
            pc_plus4 <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc + 32'd4;
        end else if (valid && ready) begin
            // Consumed with nothing new behind it.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/ERR control and IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [1:0]  fetch_err,
    output logic [1:0]  dbg_state
);

    // Handshake: an IF/ID item transfers on a rising edge where if_valid and
    // id_ready are both high; while if_valid=1 and id_ready=0 it holds stable.

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [1:0]   err_q, err_next;
    logic         load, flush, can_accept, in_range;

    assign imem_addr  = pc[9:2];
    assign can_accept = !if_valid || id_ready;
    // Full word index is compared so addresses aliasing into imem_addr still trap.
    assign in_range   = {2'b00, pc[31:2]} < 32'(IMEM_DEPTH);
    assign fetch_err  = err_q;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
            err_q <= FETCH_ERR_NONE;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            err_q <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        err_next   = err_q;
        load       = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        err_next   = FETCH_ERR_MISALIGN;
                        state_next = ST_ERR;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if (can_accept) begin
                    if (in_range) begin
                        load    = 1'b1;
                        pc_next = pc + 32'd4;
                    end else begin
                        flush      = 1'b1;
                        err_next   = FETCH_ERR_RANGE;
                        state_next = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                flush = 1'b1;
            end
            default: begin
                state_next = ST_ERR;
                flush      = 1'b1;
            end
        endcase
    end

    ifid_reg u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .ready      (id_ready),
        .load_instr (imem_instr),
        .load_pc    (pc),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4)
    );

endmodule
